// File: rtl/multi_pulse_pacer_pkg.sv
// pacer_pkg: shared definitions for multi_pulse_pacer.
//   - pacer_state_t : FSM state encoding (IDLE / OFFER / GAP)
//   - pacer_clog2   : ceil(log2(n)), minimum 1, used to size the channel index
//   - DROP_CNT_W    : width of the optional drop statistics counter
package pacer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    GAP   = 2'd2
  } pacer_state_t;

  localparam int DROP_CNT_W = 16;

  // Returns at least 1 so that a 1-channel index still has a real bit.
  function automatic int pacer_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/multi_pulse_pacer_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
// Ports:
//   req       in  NUM_CH  request vector (one bit per channel)
//   last_ptr  in  CH_W    index of the most recently granted channel
//   grant     out NUM_CH  one-hot grant (all zero when no request)
//   grant_idx out CH_W    encoded index of the granted channel
// The search starts at last_ptr+1 and wraps NUM_CH-1 -> 0.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last_ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx
);

  int  cand;
  logic found;

  // Walk the channels starting right after the last grant; the first
  // requester encountered wins. k runs to NUM_CH so last_ptr itself is
  // considered last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = (int'(last_ptr) + k) % NUM_CH;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = CH_W'(cand);
      end
    end
  end

endmodule

// File: rtl/multi_pulse_pacer.sv
// multi_pulse_pacer: multi-channel pulse accumulator and pacer.
// Each channel counts single-cycle strobes in a saturating pending counter;
// a round-robin arbiter drains them one at a time onto a valid/ready output
// tagged with the channel index, with gap_cfg idle cycles after each delivery.
// Ports:
//   clk, rst     single clock, synchronous active-high reset
//   in_pulse     per-channel one-cycle event strobes
//   gap_cfg      idle cycles forced after each delivered pulse
//   flush        synchronous clear of all pending counts (ovf kept)
//   out_valid    registered pulse offer
//   out_ch       registered channel index of the offer
//   out_ready    consumer accept
//   pending_any  registered OR of all counters non-zero
//   ovf          sticky per-channel overflow flags
//   drop_cnt     saturating dropped-pulse count (only with the macro below)
//   clr_ovf      per-channel ovf clear (a new overflow wins)
// Build option: define MULTI_PULSE_PACER_STATS_EN to add drop_cnt.
module multi_pulse_pacer
  import pacer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 4,
  parameter int GAP_W  = 8,
  localparam int CH_W  = pacer_clog2(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     in_pulse,
  input  logic [GAP_W-1:0]      gap_cfg,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [CH_W-1:0]       out_ch,
  input  logic                  out_ready,
  output logic                  pending_any,
  output logic [NUM_CH-1:0]     ovf,
`ifdef MULTI_PULSE_PACER_STATS_EN
  output logic [DROP_CNT_W-1:0] drop_cnt,
`endif
  input  logic [NUM_CH-1:0]     clr_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] dec;
  logic [NUM_CH-1:0] drop;
  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   grant_idx;
  logic [CH_W-1:0]   last_ptr;
  logic [GAP_W-1:0]  gap_cnt;
  logic              hs;
  pacer_state_t      state;

  assign hs = out_valid & out_ready;

  // Per-channel request, decrement and drop qualifiers. A pulse arriving in
  // the same cycle as that channel's handshake cancels out, so it is never a
  // drop even when the counter sits at max. Pulses during flush are discarded,
  // not dropped.
  always_comb begin
    req  = '0;
    dec  = '0;
    drop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      req[i]  = (cnt[i] != '0);
      dec[i]  = hs && (out_ch == CH_W'(i));
      drop[i] = !flush && in_pulse[i] && !dec[i] && (cnt[i] == CNT_MAX);
    end
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req       (req),
    .last_ptr  (last_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Pending counters: saturating increment, decrement on handshake.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst || flush) begin
        cnt[i] <= '0;
      end else if (in_pulse[i] && !dec[i]) begin
        if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + CNT_W'(1);
      end else if (dec[i] && !in_pulse[i]) begin
        cnt[i] <= cnt[i] - CNT_W'(1);
      end
    end
  end

  // Sticky overflow flags; a fresh overflow beats a clear in the same cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) begin
        ovf[i] <= 1'b0;
      end else if (drop[i]) begin
        ovf[i] <= 1'b1;
      end else if (clr_ovf[i]) begin
        ovf[i] <= 1'b0;
      end
    end
  end

  // Registered view of "anything pending"; lags the counters by one cycle.
  always_ff @(posedge clk) begin
    if (rst) pending_any <= 1'b0;
    else     pending_any <= |req;
  end

  // Delivery FSM. The offered channel's counter cannot reach zero while in
  // OFFER (only this FSM decrements it), so out_ch stays valid until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_ch    <= '0;
      last_ptr  <= CH_W'(NUM_CH - 1);
      gap_cnt   <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      gap_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            out_ch    <= grant_idx;
            last_ptr  <= grant_idx;
            out_valid <= 1'b1;
            state     <= OFFER;
          end
        end
        OFFER: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (gap_cfg == '0) begin
              state <= IDLE;
            end else begin
              gap_cnt <= gap_cfg;
              state   <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt <= GAP_W'(1)) state <= IDLE;
          else                      gap_cnt <= gap_cnt - GAP_W'(1);
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef MULTI_PULSE_PACER_STATS_EN
  logic [CH_W:0]       drop_num;
  logic [DROP_CNT_W:0] drop_sum;

  // Number of channels dropping this cycle, added with saturation.
  always_comb begin
    drop_num = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      drop_num = drop_num + (CH_W + 1)'(drop[i]);
    end
    drop_sum = {1'b0, drop_cnt} + (DROP_CNT_W + 1)'(drop_num);
  end

  always_ff @(posedge clk) begin
    if (rst)                   drop_cnt <= '0;
    else if (drop_sum[DROP_CNT_W]) drop_cnt <= '1;
    else                       drop_cnt <= drop_sum[DROP_CNT_W-1:0];
  end
`endif

endmodule

// File: tb/tb_multi_pulse_pacer.sv
// tb_multi_pulse_pacer: directed, self-checking bench for multi_pulse_pacer
// (NUM_CH=4, CNT_W=4, GAP_W=8). Inputs change 1 time unit after the rising
// edge; outputs are read at that same point, well away from the next edge.
module tb_multi_pulse_pacer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_pulse;
  logic [7:0] gap_cfg;
  logic       flush;
  logic       out_valid;
  logic [1:0] out_ch;
  logic       out_ready;
  logic       pending_any;
  logic [3:0] ovf;
  logic [3:0] clr_ovf;
`ifdef MULTI_PULSE_PACER_STATS_EN
  logic [15:0] drop_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  multi_pulse_pacer #(
    .NUM_CH (4),
    .CNT_W  (4),
    .GAP_W  (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_pulse    (in_pulse),
    .gap_cfg     (gap_cfg),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ch      (out_ch),
    .out_ready   (out_ready),
    .pending_any (pending_any),
    .ovf         (ovf),
`ifdef MULTI_PULSE_PACER_STATS_EN
    .drop_cnt    (drop_cnt),
`endif
    .clr_ovf     (clr_ovf)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  // Advance one cycle and settle 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Strobe the given channels for exactly one cycle.
  task automatic applyStimulus(input logic [3:0] p);
    in_pulse = p;
    tick();
    in_pulse = '0;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int         t0;
  int         n;
  int         hs_cyc [4];
  logic [1:0] hs_ch  [4];
  logic [3:0] pat    [10];

  initial begin
    rst = 1'b1; in_pulse = '0; gap_cfg = '0; flush = 1'b0;
    out_ready = 1'b0; clr_ovf = '0;
    pat = '{4'b0001, 4'b1010, 4'b0011, 4'b1000, 4'b1011,
            4'b0000, 4'b0010, 4'b1001, 4'b0001, 4'b1010};

    // ---- reset values ----
    tick();
    tick();
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_ch", out_ch, 0);
    checkOutput("rst_pending", pending_any, 0);
    checkOutput("rst_ovf", ovf, 0);
`ifdef MULTI_PULSE_PACER_STATS_EN
    checkOutput("rst_drop", drop_cnt, 0);
`endif
    rst = 1'b0;
    tick();

    // ---- single pulse on ch2, gap 0, ready 1 ----
    out_ready = 1'b1;
    applyStimulus(4'b0100);               // now t+1
    checkOutput("t1_valid_early", out_valid, 0);
    tick();                               // t+2
    checkOutput("t1_valid", out_valid, 1);
    checkOutput("t1_ch", out_ch, 2);
    checkOutput("t1_pending", pending_any, 1);
    tick();                               // t+3
    checkOutput("t1_valid_drop", out_valid, 0);
    tick();                               // t+4
    checkOutput("t1_pending_clr", pending_any, 0);
    checkOutput("t1_valid_quiet", out_valid, 0);

    // ---- all four channels, gap 3: order 0,1,2,3 spaced 5 ----
    applyReset();
    out_ready = 1'b1;
    gap_cfg   = 8'd3;
    t0 = cyc;
    applyStimulus(4'b1111);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid && out_ready) begin
        if (n < 4) begin
          hs_cyc[n] = cyc;
          hs_ch[n]  = out_ch;
        end
        n++;
      end
      tick();
    end
    checkOutput("rr_count", n, 4);
    checkOutput("rr_first_lat", hs_cyc[0] - t0, 2);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("rr_ch%0d", k), hs_ch[k], k);
      if (k > 0) checkOutput($sformatf("rr_space%0d", k), hs_cyc[k] - hs_cyc[k-1], 5);
    end

    // ---- saturation on ch1 ----
    applyReset();
    gap_cfg   = 8'd0;
    out_ready = 1'b0;
    for (int k = 0; k < 20; k++) applyStimulus(4'b0010);
    checkOutput("sat_ovf", ovf, 4'b0010);
    checkOutput("sat_valid", out_valid, 1);
    checkOutput("sat_ch", out_ch, 1);
`ifdef MULTI_PULSE_PACER_STATS_EN
    checkOutput("sat_drop", drop_cnt, 5);
`endif
    // clear and saturating pulse together: set wins
    clr_ovf = 4'b0010;
    applyStimulus(4'b0010);
    clr_ovf = '0;
    checkOutput("sat_set_wins", ovf, 4'b0010);
`ifdef MULTI_PULSE_PACER_STATS_EN
    checkOutput("sat_drop2", drop_cnt, 6);
`endif
    clr_ovf = 4'b0010;
    tick();
    clr_ovf = '0;
    checkOutput("sat_clr", ovf, 0);
    // pulse + handshake on ch1 at max: count unchanged, no overflow
    out_ready = 1'b1;
    applyStimulus(4'b0010);
    checkOutput("sat_simul_ovf", ovf, 0);
`ifdef MULTI_PULSE_PACER_STATS_EN
    checkOutput("sat_simul_drop", drop_cnt, 6);
`endif
    n = 0;
    for (int k = 0; k < 60; k++) begin
      if (out_valid) begin
        n++;
        checkOutput("sat_drain_ch", out_ch, 1);
      end
      tick();
    end
    checkOutput("sat_drain_count", n, 15);
    checkOutput("sat_drain_pending", pending_any, 0);

    // ---- stalled consumer keeps offer stable ----
    applyReset();
    out_ready = 1'b0;
    applyStimulus(4'b0100);
    tick();
    for (int k = 0; k < 10; k++) begin
      in_pulse = pat[k];
      checkOutput("stall_valid", out_valid, 1);
      checkOutput("stall_ch", out_ch, 2);
      tick();
    end
    in_pulse = '0;

    // ---- flush during OFFER with counts 3,0,5,1 ----
    applyReset();
    out_ready = 1'b0;
    applyStimulus(4'b1101);
    applyStimulus(4'b0101);
    applyStimulus(4'b0101);
    applyStimulus(4'b0100);
    applyStimulus(4'b0100);
    checkOutput("fl_valid_before", out_valid, 1);
    checkOutput("fl_ch_before", out_ch, 0);
    flush    = 1'b1;
    in_pulse = 4'b1111;
    tick();
    flush    = 1'b0;
    in_pulse = '0;
    checkOutput("fl_valid_after", out_valid, 0);
    checkOutput("fl_ovf_kept", ovf, 0);
    out_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) n++;
      tick();
    end
    checkOutput("fl_no_deliveries", n, 0);
    checkOutput("fl_pending", pending_any, 0);

    // ---- reset in the middle of GAP ----
    applyReset();
    out_ready = 1'b0;
    gap_cfg   = 8'd10;
    for (int k = 0; k < 16; k++) applyStimulus(4'b1000);
    checkOutput("rg_ovf", ovf, 4'b1000);
    checkOutput("rg_ch", out_ch, 3);
`ifdef MULTI_PULSE_PACER_STATS_EN
    checkOutput("rg_drop", drop_cnt, 1);
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("rg_in_gap", out_valid, 0);
    tick();
    tick();
    checkOutput("rg_pending_pre", pending_any, 1);
    rst = 1'b1;
    tick();
    checkOutput("rg_valid", out_valid, 0);
    checkOutput("rg_ch_rst", out_ch, 0);
    checkOutput("rg_pending", pending_any, 0);
    checkOutput("rg_ovf_rst", ovf, 0);
`ifdef MULTI_PULSE_PACER_STATS_EN
    checkOutput("rg_drop_rst", drop_cnt, 0);
`endif
    rst       = 1'b0;
    out_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 15; k++) begin
      if (out_valid) n++;
      tick();
    end
    checkOutput("rg_no_deliveries", n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
